// File: rtl/alu_issue.sv
// Register file and issue sequencer that feeds one command at a time to the ALU.
// ALU ops retire in 2 cycles and load-immediates in 1. cmd_ready is high only in IDLE, so every command fully finishes before the next is accepted.
module alu_issue #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [AW-1:0]    cmd_rd,
  input  logic [AW-1:0]    cmd_rs,
  input  logic [AW-1:0]    cmd_rt,
  input  logic             cmd_imm_en,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ins,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [WIDTH-1:0] alu_hi,
  input  logic [2:0]       alu_flags,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] hi_reg,
  output logic [2:0]       flags_reg,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, EXEC, WB, ERR} state_t;

  state_t           state;
  logic [WIDTH-1:0] regs [NREGS];
  logic [AW-1:0]    rd_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] hi_q;
  logic [2:0]       flags_q;
  logic             is_alu;

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             op_is_alu;

  // r0 is never written, so reading it straight from the array always yields 0.
  assign opa       = regs[cmd_rs];
  assign opb       = cmd_imm_en ? cmd_imm : regs[cmd_rt];
  assign op_is_alu = (cmd_op >= 4'd1) && (cmd_op <= 4'd9);
  assign cmd_ready = (state == IDLE) && !rst;
  assign dbg_data  = (dbg_addr == '0) ? '0 : regs[dbg_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      rd_q      <= '0;
      res_q     <= '0;
      hi_q      <= '0;
      flags_q   <= '0;
      is_alu    <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ins   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      hi_reg    <= '0;
      flags_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            rd_q <= cmd_rd;
            if (op_is_alu) begin
              alu_a   <= opa;
              alu_b   <= opb;
              alu_ins <= cmd_op;
              is_alu  <= 1'b1;
              state   <= EXEC;
            end else if (cmd_op == 4'd0 && cmd_imm_en) begin
              res_q  <= cmd_imm;
              is_alu <= 1'b0;
              done   <= 1'b1;
              state  <= WB;
            end else begin
              err   <= 1'b1;
              state <= ERR;
            end
          end
        end
        EXEC: begin
          res_q   <= alu_out;
          hi_q    <= alu_hi;
          flags_q <= alu_flags;
          alu_a   <= '0;
          alu_b   <= '0;
          alu_ins <= '0;
          done    <= 1'b1;
          state   <= WB;
        end
        WB: begin
          if (rd_q != '0) regs[rd_q] <= res_q;
          if (is_alu) begin
            hi_reg    <= hi_q;
            flags_reg <= flags_q;
          end
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          err   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a combinational adder standing in for the ALU.
module tb_alu_issue;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = '0;
  logic [2:0]  cmd_rd = '0, cmd_rs = '0, cmd_rt = '0;
  logic        cmd_imm_en = 1'b0;
  logic [15:0] cmd_imm = '0;
  logic [15:0] alu_a, alu_b, alu_out, alu_hi, hi_reg, dbg_data;
  logic [3:0]  alu_ins;
  logic [2:0]  alu_flags, flags_reg;
  logic        done, err;
  logic [2:0]  dbg_addr = '0;
  logic [15:0] stub_hi = '0;
  logic [2:0]  stub_flags = '0;

  int tests = 0, fails = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, cyc = 0;
  int d0, e0, n;
  int acc [3];

  always #5 clk = ~clk;

  assign alu_out   = alu_a + alu_b;
  assign alu_hi    = stub_hi;
  assign alu_flags = stub_flags;

  alu_issue dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
    .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ins(alu_ins),
    .alu_out(alu_out), .alu_hi(alu_hi), .alu_flags(alu_flags),
    .done(done), .err(err), .hi_reg(hi_reg), .flags_reg(flags_reg),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
    if (done && err) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic peek(input string tag, input logic [2:0] addr, input logic [15:0] exp);
    dbg_addr = addr;
    #1;
    check(tag, dbg_data, exp);
  endtask

  // Returns one step after the accepting edge, i.e. inside the first post-accept cycle.
  task automatic send(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                      input logic [2:0] rt, input logic imm_en, input logic [15:0] imm);
    int k = 0;
    step();
    while (!cmd_ready && k < 50) begin
      step();
      k++;
    end
    check("send_ready", cmd_ready, 1);
    cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt;
    cmd_imm_en = imm_en; cmd_imm = imm; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    step();
  endtask

  initial begin
    // Reset state
    step();
    check("rst_ready", cmd_ready, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_ins", alu_ins, 0);
    check("rst_hi", hi_reg, 0);
    check("rst_flags", flags_reg, 0);
    peek("rst_r4", 3'd4, 16'd0);
    rst = 1'b0;
    step();
    check("post_rst_ready", cmd_ready, 1);

    // Load then ALU op
    send(4'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'd511);
    check("li_done", done, 1);
    check("li_err", err, 0);
    step();
    check("li_done_low", done, 0);
    peek("li_r1", 3'd1, 16'd511);
    send(4'd0, 3'd2, 3'd0, 3'd0, 1'b1, 16'd3);
    step();
    stub_hi = 16'h00AB; stub_flags = 3'b101;
    send(4'd1, 3'd3, 3'd1, 3'd2, 1'b0, 16'd0);
    check("ex_alu_a", alu_a, 16'd511);
    check("ex_alu_b", alu_b, 16'd3);
    check("ex_alu_ins", alu_ins, 4'd1);
    check("ex_done", done, 0);
    step();
    check("wb_done", done, 1);
    check("wb_alu_ins", alu_ins, 0);
    check("wb_hi_not_yet", hi_reg, 0);
    step();
    peek("op1_r3", 3'd3, 16'd514);
    check("op1_hi", hi_reg, 16'h00AB);
    check("op1_flags", flags_reg, 3'b101);
    check("op1_ready", cmd_ready, 1);
    check("done_count3", done_cnt, 3);

    // Sweep ALU ops with immediate B
    d0 = done_cnt;
    for (int op = 1; op <= 9; op++) begin
      stub_hi = 16'h0A00 + 16'(op);
      send(4'(op), 3'd5, 3'd1, 3'd0, 1'b1, 16'd3);
      check("sweep_ins", alu_ins, op);
      check("sweep_b", alu_b, 16'd3);
      step();
      step();
    end
    check("sweep_done_cnt", done_cnt - d0, 9);
    check("sweep_err_cnt", err_cnt, 0);
    peek("sweep_r5", 3'd5, 16'd514);
    check("sweep_hi", hi_reg, 16'h0A09);

    // r0 protection
    send(4'd0, 3'd0, 3'd0, 3'd0, 1'b1, 16'h1234);
    check("r0_li_done", done, 1);
    step();
    peek("r0_after_li", 3'd0, 16'd0);
    stub_hi = 16'h5555; stub_flags = 3'b010;
    send(4'd5, 3'd0, 3'd1, 3'd2, 1'b0, 16'd0);
    step();
    step();
    check("r0_op_hi", hi_reg, 16'h5555);
    check("r0_op_flags", flags_reg, 3'b010);
    peek("r0_after_op", 3'd0, 16'd0);

    // Illegal ops
    e0 = err_cnt;
    send(4'd12, 3'd1, 3'd1, 3'd2, 1'b0, 16'hFFFF);
    check("ill12_err", err, 1);
    check("ill12_done", done, 0);
    check("ill12_ins", alu_ins, 0);
    step();
    check("ill12_err_low", err, 0);
    check("ill12_ready", cmd_ready, 1);
    send(4'd0, 3'd2, 3'd1, 3'd1, 1'b0, 16'hBEEF);
    check("ill0_err", err, 1);
    check("ill0_ins", alu_ins, 0);
    step();
    check("ill_err_cnt", err_cnt - e0, 2);
    peek("ill_r1", 3'd1, 16'd511);
    peek("ill_r2", 3'd2, 16'd3);
    check("ill_hi", hi_reg, 16'h5555);
    check("ill_flags", flags_reg, 3'b010);

    // Continuous valid with three dependent ALU ops
    stub_hi = 16'h0001; stub_flags = 3'b001;
    cmd_op = 4'd2; cmd_rd = 3'd6; cmd_rs = 3'd0; cmd_rt = 3'd0;
    cmd_imm_en = 1'b1; cmd_imm = 16'd10; cmd_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      step();
      while (!cmd_ready && n < 20) begin
        step();
        n++;
      end
      check("hs_ready", cmd_ready, 1);
      acc[k] = cyc;
      @(posedge clk);
      #1;
      if (k == 0) begin
        cmd_op = 4'd3; cmd_rd = 3'd7; cmd_rs = 3'd6; cmd_imm = 16'd5;
      end else if (k == 1) begin
        cmd_op = 4'd4; cmd_rd = 3'd6; cmd_rs = 3'd7; cmd_imm = 16'd1;
      end else begin
        cmd_valid = 1'b0;
      end
    end
    check("hs_gap01", acc[1] - acc[0], 3);
    check("hs_gap12", acc[2] - acc[1], 3);
    step();
    step();
    step();
    peek("dep_r7", 3'd7, 16'd15);
    peek("dep_r6", 3'd6, 16'd16);

    // Reset during EXEC abandons the command
    d0 = done_cnt;
    send(4'd1, 3'd4, 3'd1, 3'd2, 1'b0, 16'd0);
    check("mid_exec_ins", alu_ins, 4'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", cmd_ready, 0);
    check("mid_rst_ins", alu_ins, 0);
    step();
    check("mid_rst_done", done, 0);
    check("mid_rst_hi", hi_reg, 0);
    step();
    rst = 1'b0;
    #1;
    check("mid_rel_ready", cmd_ready, 1);
    step();
    step();
    check("mid_done_cnt", done_cnt - d0, 0);
    peek("mid_r4", 3'd4, 16'd0);
    peek("mid_r1", 3'd1, 16'd0);
    check("never_both", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_issue.md
# alu_issue

Register-file and issue sequencer that sits directly upstream of `alu`. It accepts one command at a time over a valid/ready handshake and reads source operands from an 8 x 16-bit register file. It drives the ALU's `A`, `B` and `ins` inputs, captures `out`, `hi` and `flags`, and writes results back to the register file, a HI register and a flags register.

## Interface
- `WIDTH`, 16: datapath width; must match the ALU.
- `NREGS`, 8: register-file depth; address width is log2(NREGS) = 3.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_op`  in  4  opcode: 0 = load immediate, 1..9 = ALU op passed to `ins`, 10..15 illegal.
- `cmd_rd`  in  3  destination register.
- `cmd_rs`  in  3  source register for `A`.
- `cmd_rt`  in  3  source register for `B`, used when `cmd_imm_en`=0.
- `cmd_imm_en`  in  1  `B` (or load value) taken from `cmd_imm`.
- `cmd_imm`  in  16  immediate.
- `alu_a`, `alu_b`  out  16  to ALU `A`, `B`.
- `alu_ins`  out  4  to ALU `ins`.
- `alu_out`, `alu_hi`  in  16  from ALU `out`, `hi`.
- `alu_flags`  in  3  from ALU `flags`.
- `done`  out  1  one-cycle pulse: command retired.
- `err`  out  1  one-cycle pulse: command rejected.
- `hi_reg`  out  16  last captured `hi`.
- `flags_reg`  out  3  last captured `flags`.
- `dbg_addr`  in  3  debug read address.
- `dbg_data`  out  16  combinational read of `regs[dbg_addr]`.

## Operation
- States: IDLE, EXEC, WB, ERR.
- `cmd_ready` = (state==IDLE) && !rst.
- IDLE, on accept (`cmd_valid` && `cmd_ready` at a clock edge), the command's fields are latched:
  - operand A = `regs[cmd_rs]`;
  - operand B = `cmd_imm_en` ? `cmd_imm` : `regs[cmd_rt]`.
  - `cmd_op` 1..9: go to EXEC.
  - `cmd_op`=0 with `cmd_imm_en`=1: go to WB with the result = `cmd_imm`; HI and flags are not updated.
  - `cmd_op`=0 with `cmd_imm_en`=0, or `cmd_op` 10..15: go to ERR.
- EXEC:
  - `alu_a`, `alu_b`, `alu_ins` are driven from the latched operands and op.
  - At the end of the cycle `alu_out`, `alu_hi` and `alu_flags` are registered; go to WB.
- Outside EXEC, `alu_a`=`alu_b`=0 and `alu_ins`=0.
- WB:
  - `done`=1.
  - At the end of the cycle `regs[rd]` is written, except when rd=0; r0 reads 0 always.
  - For ALU ops only, `hi_reg` and `flags_reg` are written.
  - Go to IDLE.
- ERR: `err`=1; nothing is written; go to IDLE.
- All values are 16-bit; no sign extension or truncation occurs in this block.

## Timing
- Reset (async assert, any state):
  - state = IDLE;
  - all registers = 0;
  - `hi_reg`=0, `flags_reg`=0;
  - `done`=0, `err`=0;
  - `alu_a`=`alu_b`=0, `alu_ins`=0;
  - `cmd_ready`=0 while `rst` is high.
- Reset mid-command abandons it: no write-back, no `done`.
- ALU op latency: accepted at edge E0, `alu_*` valid during E0..E1, `done` high during E1..E2, register visible on `dbg_data` after E2, `cmd_ready` high after E2. Throughput is 1 command per 3 cycles.
- Load-immediate: accepted at E0, `done` during E0..E1, register written at E1.
- Illegal op: accepted at E0, `err` during E0..E1, `cmd_ready` back after E1.
- Back-to-back commands: a command whose source is the previous command's rd reads the written value; no bypass is needed because write-back completes before the next accept.
- `cmd_valid` held while `cmd_ready`=0 is not consumed. Command fields are sampled only at the accepting edge.
- `done` and `err` are never high together.

## Test plan
- Reset mid-EXEC: assert `rst` during EXEC of op 1 targeting r4 -> `done` never pulses, `dbg_data`(r4)=0, `cmd_ready`=1 in the cycle after `rst` deasserts.
- Load then ALU op: LI r1=511, LI r2=3, then op 1 with rd=r3, rs=r1, rt=r2; ALU stub returns out=514, hi=0x00AB, flags=3'b101.
  - During EXEC: `alu_a`=511, `alu_b`=3, `alu_ins`=1.
  - Afterwards: r3=514, `hi_reg`=0x00AB, `flags_reg`=101.
  - `done` pulses once per command.
- Sweep ins 1..9: A=511, B=3 (immediate) -> `alu_ins` equals `cmd_op` in EXEC for each op, 9 `done` pulses, 0 `err` pulses.
- r0 protection: LI r0=0x1234 -> `done`=1, and r0 reads 0. An ALU op with rd=0 still updates `hi_reg` and `flags_reg`.
- Illegal ops: `cmd_op`=12, and `cmd_op`=0 with `cmd_imm_en`=0 -> `err` for one cycle each, no register, HI or flags change, `alu_ins` stays 0.
- Handshake and dependency: `cmd_valid` held high continuously with 3 queued commands -> acceptances spaced 3 cycles apart. A dependent op reading the prior rd gets the new value.
